serial_subtractor: RTL and testbench

//  Bit-serial two's-complement subtractor: computes DIFF = A - B - BIN, LSB first, one bit per clock.

---
 rtl/serial_subtractor.sv | 123 ++++++++++++
 tb/tb_serial_subtractor.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: DIFF = A - B - BIN, one bit per clock, LSB first.
// A single full-subtractor cell and a borrow flop are wrapped in an IDLE/SHIFT/DONE handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, work_q, work_d, diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d, br_msb_q, br_msb_d;
    logic             busy_q, busy_d, done_q, done_d, bout_q, bout_d, ovf_q, ovf_d;
    logic             a0, b0, d_bit, br_nxt;

    assign a0     = a_q[0];
    assign b0     = b_q[0];
    assign d_bit  = a0 ^ b0 ^ br_q;
    assign br_nxt = (~a0 & b0) | (~(a0 ^ b0) & br_q);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        br_msb_d = br_msb_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                work_d = {d_bit, work_q[WIDTH-1:1]};
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                br_d   = br_nxt;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // br_q here is the borrow entering the sign bit
                    br_msb_d = br_q;
                    state_d  = DONE;
                end
            end
            DONE: begin
                done_d = 1'b1;
                diff_d = work_q;
                bout_d = br_q;
                ovf_d  = br_msb_q ^ br_q;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            br_msb_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            br_msb_q <= br_msb_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected results, a monitor pops on done.
module tb_serial_subtractor;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         bin = 1'b0;
    logic         busy, done, bout, ovf;
    logic [W-1:0] diff;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0, failures = 0;
    int           cyc = 0;
    logic [W-1:0] last_diff = '0;
    logic         last_bout = 1'b0, last_ovf = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compare on every done pulse; otherwise the result registers must hold
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("diff", 32'(diff), 32'(e.diff));
                    check("bout", 32'(bout), 32'(e.bout));
                    check("ovf", 32'(ovf), 32'(e.ovf));
                    check("latency", 32'(cyc), 32'(e.cyc));
                    last_diff = e.diff;
                    last_bout = e.bout;
                    last_ovf  = e.ovf;
                end
            end else begin
                check("hold_diff", 32'(diff), 32'(last_diff));
                check("hold_flags", 32'({bout, ovf}), 32'({last_bout, last_ovf}));
            end
        end
    end

    // Drive start with operands; returns just after the accepting edge with start still high
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                         input logic [W-1:0] ed, input logic eb, input logic eo);
        exp_t e;
        @(negedge clk);
        a = ta; b = tb_; bin = tbin; start = 1'b1;
        @(posedge clk);
        #1;
        e.diff = ed; e.bout = eb; e.ovf = eo; e.cyc = cyc + W + 1;
        sb.push_back(e);
        check("busy_after_start", 32'(busy), 32'(1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout: got %0d pending ops expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic single(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                          input logic [W-1:0] ed, input logic eb, input logic eo);
        issue(ta, tb_, tbin, ed, eb, eo);
        start = 1'b0;
        drain();
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rbin;
        int           s;

        #12;
        check("rst_outputs", 32'({busy, done, bout, ovf, diff}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outputs", 32'({busy, done, bout, ovf, diff}), 32'(0));

        single(8'd200, 8'd55, 1'b0, 8'd145, 1'b0, 1'b0);
        single(8'd5,   8'd10, 1'b0, 8'hFB,  1'b1, 1'b0);
        single(8'd0,   8'd0,  1'b1, 8'hFF,  1'b1, 1'b0);
        single(8'h80,  8'h01, 1'b0, 8'h7F,  1'b0, 1'b1);
        single(8'h7F,  8'hFF, 1'b0, 8'h80,  1'b1, 1'b1);

        // Start pulse in the middle of SHIFT must be ignored
        issue(8'd100, 8'd30, 1'b0, 8'd70, 1'b0, 1'b0);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a = 8'd1; b = 8'd2; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (12) @(negedge clk);

        // Async reset in the middle of SHIFT aborts the operation
        issue(8'd9, 8'd3, 1'b0, 8'd6, 1'b0, 1'b0);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 32'({busy, done, bout, ovf, diff}), 32'(0));
        sb.delete();
        last_diff = '0; last_bout = 1'b0; last_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (14) @(negedge clk);
        single(8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1);

        // Back-to-back with start held high through DONE
        issue(8'd10, 8'd3, 1'b1, 8'd6, 1'b0, 1'b0);
        repeat (W) @(posedge clk);
        issue(8'd3, 8'd10, 1'b0, 8'hF9, 1'b1, 1'b0);
        repeat (W) @(posedge clk);
        issue(8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            logic [W:0] wide;
            repeat (W) @(posedge clk);
            ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
            wide = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
            s = int'($signed(ra)) - int'($signed(rb)) - int'(rbin);
            issue(ra, rb, rbin, wide[W-1:0], wide[W], (s < -128) || (s > 127));
        end
        start = 1'b0;
        drain();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
